// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetch/decode/exec/mem/wb sequencer for the 8-bit datapath.
// Owns the PC and instruction register; control outputs are Moore-decoded from state + IR.
module controle_multiciclo #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    output logic [7:0]  pc,
    output logic [2:0]  ULAControl,
    output logic        SrcBSel,
    input  logic        FlagZ,
    output logic [1:0]  rd,
    output logic [1:0]  ra,
    output logic [1:0]  rb,
    output logic [7:0]  imm,
    output logic        RegWrite,
    output logic        WBSel,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t      state, state_nxt;
    logic [15:0] ir, ir_nxt;
    logic [7:0]  pc_nxt;
    logic [3:0]  op;

    assign op  = ir[15:12];
    assign rd  = ir[11:10];
    assign ra  = ir[9:8];
    assign rb  = ir[7:6];
    assign imm = ir[7:0];

    function automatic logic [2:0] ula_decode(input logic [3:0] opc);
        case (opc)
            OP_AND:  return 3'b000;
            OP_OR:   return 3'b001;
            OP_NOR:  return 3'b011;
            OP_XOR:  return 3'b100;
            OP_SLT:  return 3'b111;
            OP_BEQ:  return 3'b110;
            OP_BNE:  return 3'b101;
            default: return 3'b010;
        endcase
    endfunction

    // Offset is two's complement; the 8-bit sum wraps modulo 256 by construction.
    function automatic logic [7:0] branch_target(input logic [7:0] base,
                                                 input logic signed [7:0] off);
        return base + $unsigned(off);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= PC_RESET;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_FETCH: begin
                ir_nxt    = instr;
                pc_nxt    = pc + 8'd1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_JMP: begin
                        pc_nxt    = imm;
                        state_nxt = S_FETCH;
                    end
                    OP_HALT:             state_nxt = S_HALT;
                    4'd12, 4'd13, 4'd14: state_nxt = S_FETCH;
                    default:             state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_nxt = S_MEM;
                end else if (op == OP_BEQ || op == OP_BNE) begin
                    if (FlagZ) pc_nxt = branch_target(pc, imm);
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ULAControl = 3'b010;
        SrcBSel    = 1'b0;
        RegWrite   = 1'b0;
        WBSel      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        halted     = 1'b0;
        case (state)
            S_EXEC, S_MEM: begin
                ULAControl = ula_decode(op);
                SrcBSel    = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
                if (state == S_MEM) begin
                    mem_read  = (op == OP_LW);
                    mem_write = (op == OP_SW);
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                WBSel    = (op == OP_LW);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the 8-bit datapath. It fetches 16-bit instructions, decodes them, and drives the ALU (`ULAControl`, B-operand select). It consumes `FlagZ` to resolve branches, sequences register-file write-back and data-memory accesses with a ready handshake, and owns the PC and instruction register.

## Interface
Parameters:
- `PC_RESET`, 8'h00, PC value loaded on reset

Ports:
- `clk` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-high
- `instr` in 16 instruction memory data; combinational read at `pc`
- `pc` out 8 instruction address (registered)
- `ULAControl` out 3 ALU operation select
- `SrcBSel` out 1 ALU B operand: 0 = register `rb`, 1 = `imm`
- `FlagZ` in 1 ALU zero/branch flag
- `rd`, `ra`, `rb` out 2 each; register-file addresses from IR[11:10], IR[9:8], IR[7:6]
- `imm` out 8 IR[7:0]
- `RegWrite` out 1 register-file write strobe
- `WBSel` out 1 write-back source: 0 = ALU result, 1 = memory data
- `mem_read`, `mem_write` out 1 each; data-memory request, address = ALU result
- `mem_ready` in 1 data-memory completion
- `halted` out 1 HALT reached

## Operation
- Opcode is IR[15:12].
  - 0 AND: ULA 000
  - 1 OR: ULA 001
  - 2 ADD: ULA 010
  - 3 NOR: ULA 011
  - 4 XOR: ULA 100
  - 5 SLT: ULA 111
  - 6 ADDI: ULA 010, SrcBSel = 1
  - 7 BEQ: ULA 110
  - 8 BNE: ULA 101
  - 9 LW: ULA 010, SrcBSel = 1
  - 10 SW: ULA 010, SrcBSel = 1
  - 11 JMP
  - 15 HALT
  - 12–14 are NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `ir <= instr`; `pc <= pc+1` (wraps 255→0). Next state: DECODE.
- DECODE:
  - JMP: `pc <= imm`, then FETCH.
  - HALT: go to HALT.
  - NOP opcodes: go to FETCH.
  - Otherwise: go to EXEC.
- EXEC: drives the opcode's ULAControl and SrcBSel.
  - ALU ops: go to WB.
  - LW, SW: go to MEM.
  - BEQ/BNE: if `FlagZ`=1, `pc <= pc + imm` (imm two's complement, mod 256, relative to the already-incremented pc). Then FETCH.
- MEM: holds ULAControl/SrcBSel of EXEC. Asserts `mem_read` (LW) or `mem_write` (SW) continuously until `mem_ready`=1.
  - On ready, LW goes to WB; SW goes to FETCH.
  - `mem_ready` already high on MEM entry completes MEM in one cycle.
- WB: `RegWrite`=1 for exactly one cycle. `WBSel`=1 for LW, 0 otherwise. Next state: FETCH.
- HALT: absorbing. `halted`=1, all strobes 0, pc frozen; only `reset` exits.
- Control outputs are Moore-decoded from state + IR.
  - Outside EXEC/MEM: ULAControl = 010, SrcBSel = 0.
  - `RegWrite`, `mem_read`, `mem_write` are 0 outside WB/MEM.
  - `rd/ra/rb/imm` always reflect IR.

## Timing
- Reset (async, any state, including MEM mid-wait): state = FETCH, pc = `PC_RESET`, ir = 0, `halted` = 0. All strobes drop immediately.
- Cycles per instruction:
  - JMP, NOP: 2
  - BEQ/BNE: 3
  - ALU ops: 4
  - SW: 4 + wait cycles
  - LW: 5 + wait cycles
- Branch/jump PC update becomes visible on `pc` the cycle after EXEC/DECODE.
- `FlagZ` is sampled only in EXEC of BEQ/BNE and ignored otherwise.
- `mem_ready` is ignored outside MEM.
- Branch target and PC increment both use 8-bit modulo arithmetic. No overflow indication.

## Test plan
- Reset release, `instr` = 16'h2E40 (ADD rd=3, ra=2, rb=1):
  - states are FETCH, DECODE, EXEC, WB
  - `ULAControl`=010 in EXEC; `RegWrite`=1 only in cycle 4 with `rd`=3, `WBSel`=0
  - `pc`=1 after cycle 1
- BEQ at pc=4, imm=8'hFC, `FlagZ`=1 in EXEC → `pc`=1 next cycle. Same with `FlagZ`=0 → `pc`=5. BNE drives ULAControl=101.
- LW, `mem_ready` low 3 cycles then high → `mem_read` high for 4 MEM cycles; then WB with `WBSel`=1, `RegWrite`=1; 8 cycles total.
- JMP imm=8'hFF, then FETCH at pc=255 → `pc`=0 (wrap). Opcode 13 → back to FETCH after DECODE, no strobes.
- HALT → `halted`=1 and pc frozen for 20 cycles regardless of `instr`/`mem_ready`. Then `reset` pulse → pc=0, `halted`=0.
- `reset` asserted during the MEM wait of SW → `mem_write` falls immediately without a clock edge. After release, fetch restarts at `PC_RESET`.
